// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Plays the keypad side of a 4x4 active-low scan matrix. Queued key codes
//   are pressed one at a time: each press lasts HOLD_CYCLES clocks, followed
//   by GAP_CYCLES clocks of release. While a key is pressed, its row line is
//   pulled low whenever the scanner drives that key's column low.
//
// Handshake: a key code is transferred on every rising edge where
//   key_valid && key_ready. key_valid may be asserted at any time.
//   key_ready depends only on the FIFO occupancy and never on key_valid.
//   A code offered while key_ready is low is not stored.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   col[3:0]    : column drive from scanner, active low
//   row[3:0]    : row lines to scanner, active low, registered
//   key_code    : hex key to press
//   key_valid   : key_code valid this cycle
//   key_ready   : FIFO not full
//   key_active  : high while a key is held pressed
//   cur_code    : code of the key being pressed / last pressed
//   fifo_count  : number of queued codes
//   fsm_state   : current FSM state (0 idle, 1 press, 2 release), for debug
module keypad_emulator #(
  parameter int HOLD_CYCLES = 500000,
  parameter int GAP_CYCLES  = 500000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    col,
  output logic [3:0]                    row,
  input  logic [3:0]                    key_code,
  input  logic                          key_valid,
  output logic                          key_ready,
  output logic                          key_active,
  output logic [3:0]                    cur_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    fsm_state
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int MAXC  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW    = $clog2(MAXC + 1);

  // Counters are loaded with N-1 and the state is left when they reach 0,
  // giving exactly N cycles in the state.
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT1      = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic           pop;
  logic           push;

  logic [3:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;

  logic [1:0]     kc, kr;
  logic [3:0]     row_next;

  assign key_ready  = (count != FULL);
  assign push       = key_valid && key_ready;
  assign fifo_count = count;
  assign key_active = (state == PRESS);
  assign fsm_state  = state;

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= key_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + CNT1;
      end else if (pop && !push) begin
        count <= count - CNT1;
      end
    end
  end

  // FSM state register, hold/gap counter, current code, registered rows
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_code <= 4'h0;
      row      <= 4'hF;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      row   <= row_next;
      if (pop) begin
        cur_code <= mem[rd_ptr];
      end
    end
  end

  // Next-state logic. Pops happen only here, and only when the FIFO holds data.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = PRESS;
          cnt_next   = HOLD_LOAD;
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          state_next = RELEASE;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      RELEASE: begin
        if (cnt == '0) begin
          // Chain straight into the next press so there is no idle cycle.
          if (count != '0) begin
            pop        = 1'b1;
            state_next = PRESS;
            cnt_next   = HOLD_LOAD;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Key position: kc = 0 is the column driven by col[3], kr = 0 is row[3].
  always_comb begin
    kc = 2'd0;
    kr = 2'd0;
    case (cur_code)
      4'h1: begin kc = 2'd0; kr = 2'd0; end
      4'h4: begin kc = 2'd0; kr = 2'd1; end
      4'h7: begin kc = 2'd0; kr = 2'd2; end
      4'h0: begin kc = 2'd0; kr = 2'd3; end
      4'h2: begin kc = 2'd1; kr = 2'd0; end
      4'h5: begin kc = 2'd1; kr = 2'd1; end
      4'h8: begin kc = 2'd1; kr = 2'd2; end
      4'hF: begin kc = 2'd1; kr = 2'd3; end
      4'h3: begin kc = 2'd2; kr = 2'd0; end
      4'h6: begin kc = 2'd2; kr = 2'd1; end
      4'h9: begin kc = 2'd2; kr = 2'd2; end
      4'hE: begin kc = 2'd2; kr = 2'd3; end
      4'hA: begin kc = 2'd3; kr = 2'd0; end
      4'hB: begin kc = 2'd3; kr = 2'd1; end
      4'hC: begin kc = 2'd3; kr = 2'd2; end
      4'hD: begin kc = 2'd3; kr = 2'd3; end
      default: begin kc = 2'd0; kr = 2'd0; end
    endcase
  end

  // The row follows the column drive like a closed switch in a physical matrix,
  // so several low columns are handled naturally.
  always_comb begin
    row_next = 4'hF;
    if (key_active && (col[2'd3 - kc] == 1'b0)) begin
      row_next[2'd3 - kr] = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator
//   Directed and randomized stimulus for keypad_emulator. The reference model
//   is a press timeline: each accepted code gets an accept edge and a press
//   start edge, and every output is derived from that timeline and the key map.
module tb_keypad_emulator;

  localparam int HOLD  = 20;
  localparam int GAP   = 10;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]    col, row, key_code, cur_code;
  logic          key_valid, key_ready, key_active;
  logic [CW-1:0] fifo_count;
  logic [1:0]    fsm_state;

  keypad_emulator #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col        (col),
    .row        (row),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_active (key_active),
    .cur_code   (cur_code),
    .fifo_count (fifo_count),
    .fsm_state  (fsm_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // reference model: press timeline since the last reset
  int         acc_t[$];
  int         st_t[$];
  logic [3:0] codes[$];
  logic [3:0] m_cur      = 4'h0;
  logic       m_active   = 1'b0;
  int         m_count    = 0;
  logic       m_accepted = 1'b0;

  // keys[kc][kr]: kc counts from the col 0111 column, kr from the row 0111 row
  logic [3:0] keys [4][4] = '{'{4'h1, 4'h4, 4'h7, 4'h0},
                              '{4'h2, 4'h5, 4'h8, 4'hF},
                              '{4'h3, 4'h6, 4'h9, 4'hE},
                              '{4'hA, 4'hB, 4'hC, 4'hD}};

  logic [3:0] one_low [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [3:0] exp_row(input logic act, input logic [3:0] code,
                                         input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int kc = 0; kc < 4; kc++) begin
      for (int kr = 0; kr < 4; kr++) begin
        if (act && keys[kc][kr] == code && c[3 - kc] == 1'b0) r[3 - kr] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // one clock: model update at the edge, output checks 1 time unit later
  task automatic tick();
    logic [3:0] er;
    int         st;
    @(posedge clk);
    cyc++;
    // rows register the previous cycle's press state against the col in force
    er = rst ? 4'hF : exp_row(m_active, m_cur, col);
    m_accepted = 1'b0;
    if (rst) begin
      acc_t.delete();
      st_t.delete();
      codes.delete();
      m_cur = 4'h0;
    end else if (key_valid && m_count != DEPTH) begin
      st = cyc + 1;
      if (st_t.size() > 0 && st_t[st_t.size()-1] + HOLD + GAP > st)
        st = st_t[st_t.size()-1] + HOLD + GAP;
      acc_t.push_back(cyc);
      st_t.push_back(st);
      codes.push_back(key_code);
      m_accepted = 1'b1;
    end
    m_active = 1'b0;
    m_count  = 0;
    foreach (st_t[i]) begin
      if (acc_t[i] <= cyc && cyc < st_t[i]) m_count++;
      if (st_t[i] <= cyc && cyc < st_t[i] + HOLD) m_active = 1'b1;
      if (st_t[i] <= cyc) m_cur = codes[i];
    end
    #1;
    chk("row",        {4'h0, row},        {4'h0, er});
    chk("key_active", {7'h0, key_active}, {7'h0, m_active});
    chk("cur_code",   {4'h0, cur_code},   {4'h0, m_cur});
    chk("fifo_count", 8'(fifo_count),     8'(m_count));
    chk("key_ready",  {7'h0, key_ready},  {7'h0, (m_count != DEPTH)});
  endtask

  // driver: offer a code until accepted; key_valid is left high
  task automatic push(input logic [3:0] c);
    logic got;
    got       = 1'b0;
    key_code  = c;
    key_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      got = m_accepted;
    end
    n_cmp++;
    assert (got) else begin
      n_fail++;
      $error("FAIL push_timeout: observed not accepted expected accepted code %h", c);
    end
  endtask

  task automatic idle(input int n);
    key_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    col       = 4'hF;
    key_code  = 4'h0;
    key_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    idle(3);

    // basic press, key 1 on column 0111
    col = 4'b0111;
    push(4'h1);
    idle(35);

    // column selectivity with key F
    push(4'hF);
    idle(5);
    col = 4'b1011;
    idle(6);
    col = 4'b0111;
    idle(30);

    // full map sweep, col rotating through one-low patterns every clock
    for (int c = 0; c < 16; c++) begin
      push(4'(c));
      key_valid = 1'b0;
      for (int j = 0; j < 30; j++) begin
        col = one_low[j % 4];
        tick();
      end
    end

    // back-pressure: valid held high across five codes
    col = 4'b0111;
    for (int c = 1; c <= 5; c++) push(4'(c));
    idle(5 * (HOLD + GAP) + 5);

    // reset mid-press with two codes queued; a code is also offered during reset
    push(4'h2);
    push(4'h5);
    push(4'h8);
    idle(4);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h7;
    tick();
    rst = 1'b0;
    idle(60);

    // multi-column drive with key d
    col = 4'b0000;
    push(4'hD);
    idle(6);
    col = 4'b1111;
    idle(5);
    col = 4'b0000;
    idle(25);

    // randomized traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      col       = ($urandom_range(0, 1) == 0) ? one_low[$urandom_range(0, 3)] : 4'($urandom);
      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 4'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
